// File: rtl/pci_pkg.sv
// Shared PCI bus definitions: memory commands and the memory-target state encoding.
package pci_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BUSY  = 3'd1,
        ST_WR    = 3'd2,
        ST_RD_TA = 3'd3,
        ST_RD    = 3'd4,
        ST_DONE  = 3'd5
    } target_state_e;

    // True for the two commands the memory target answers.
    function automatic logic is_mem_cmd(input logic [3:0] cmd);
        return (cmd == CMD_MEM_READ) || (cmd == CMD_MEM_WRITE);
    endfunction

endpackage

// File: rtl/pci_target_mem_array.sv
// Word array behind the PCI memory target: per-byte write enables,
// synchronous write, combinational read, contents not reset.
module pci_target_mem_array #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // Byte-lane write of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/pci_target_mem.sv
// PCI memory-space target: window decode, single/burst read and write,
// programmable initial read latency and disconnect at the top word.
//
// Handshake: a data phase completes on a rising CLK edge that samples
// IRDY=0 and TRDY=0 together; either side high means a wait state and
// nothing moves. FRAME=1 on a completing edge marks the last data phase.
module pci_target_mem
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 7,
    parameter int          RD_WAIT   = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FRAME,
    input  logic        IRDY,
    input  logic [3:0]  CBE,
    inout  wire  [31:0] AD,
    output logic        TRDY,
    output logic        DEVSEL,
    output logic        STOP
);

    target_state_e     state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic [2:0]        wait_cnt, wait_nxt;
    logic              stop_hold, stop_hold_nxt;  // disconnected, waiting for FRAME=1
    logic              addr_hit;
    logic              at_last;
    logic              trdy_act;
    logic              xfer;
    logic              ad_drive;
    logic              mem_we;
    logic [31:0]       rd_data;

    assign addr_hit = (AD[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) && (AD[1:0] == 2'b00);
    assign at_last  = (idx == '1);
    assign mem_we   = xfer && (state == ST_WR);

    // Bus state, word index, read wait counter and disconnect flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            idx       <= '0;
            wait_cnt  <= '0;
            stop_hold <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            wait_cnt  <= wait_nxt;
            stop_hold <= stop_hold_nxt;
        end
    end

    // Next-state decode and active-low bus outputs.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        wait_nxt      = wait_cnt;
        stop_hold_nxt = stop_hold;
        TRDY          = 1'b1;
        DEVSEL        = 1'b1;
        STOP          = 1'b1;
        ad_drive      = 1'b0;
        trdy_act      = 1'b0;
        xfer          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!FRAME) begin
                    if (addr_hit && is_mem_cmd(CBE)) begin
                        idx_nxt   = AD[ADDR_W+1:2];
                        state_nxt = (CBE == CMD_MEM_READ) ? ST_RD_TA : ST_WR;
                    end else begin
                        state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (FRAME && IRDY) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RD_TA: begin
                // Turnaround: claim the bus but leave AD to the initiator.
                DEVSEL    = 1'b0;
                wait_nxt  = 3'(RD_WAIT);
                state_nxt = ST_RD;
            end
            ST_WR, ST_RD: begin
                DEVSEL = 1'b0;
                if (stop_hold) begin
                    STOP = 1'b0;
                    if (FRAME) begin
                        stop_hold_nxt = 1'b0;
                        state_nxt     = ST_DONE;
                    end
                end else begin
                    trdy_act = (state == ST_WR) || (wait_cnt == 3'd0);
                    ad_drive = (state == ST_RD);
                    TRDY     = !trdy_act;
                    STOP     = !(trdy_act && at_last);
                    if ((state == ST_RD) && (wait_cnt != 3'd0)) begin
                        wait_nxt = wait_cnt - 3'd1;
                    end
                    xfer = trdy_act && !IRDY;
                    if (xfer) begin
                        // Index saturates at the top word; disconnect ends the burst there.
                        if (!at_last) begin
                            idx_nxt = idx + 1'b1;
                        end
                        if (FRAME) begin
                            state_nxt = ST_DONE;
                        end else if (at_last) begin
                            stop_hold_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign AD = ad_drive ? rd_data : 32'bz;

    pci_target_mem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (CLK),
        .we   (mem_we),
        .be   (~CBE),
        .addr (idx),
        .wdata(AD),
        .rdata(rd_data)
    );

endmodule

// File: tb/tb_pci_target_mem.sv
// Bench for pci_target_mem: two targets on one bus (no read wait and
// RD_WAIT=2), directed transactions, read-data scoreboard.
module tb_pci_target_mem;
    import pci_pkg::*;

    localparam int          ADDR_W = 7;
    localparam int          DEPTH  = 2**ADDR_W;
    localparam logic [31:0] BASE0  = 32'h0000_0000;
    localparam logic [31:0] BASE1  = 32'h0000_1000;

    // ---------------- clock / reset / bus ----------------
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame = 1'b1;
    logic        irdy  = 1'b1;
    logic [3:0]  cbe   = 4'h0;
    logic        tb_oe = 1'b0;
    logic [31:0] tb_ad = 32'h0;
    wire  [31:0] ad;
    logic        trdy0, devsel0, stop0;
    logic        trdy1, devsel1, stop1;
    logic        trdy, devsel, stop, ad_busy;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ad      = tb_oe ? tb_ad : 32'bz;
    assign trdy    = trdy0 & trdy1;
    assign devsel  = devsel0 & devsel1;
    assign stop    = stop0 & stop1;
    assign ad_busy = dut0.ad_drive | dut1.ad_drive;

    pci_target_mem #(.BASE_ADDR(BASE0), .ADDR_W(ADDR_W), .RD_WAIT(0)) dut0 (
        .CLK(clk), .RST(rst_n), .FRAME(frame), .IRDY(irdy), .CBE(cbe), .AD(ad),
        .TRDY(trdy0), .DEVSEL(devsel0), .STOP(stop0)
    );

    pci_target_mem #(.BASE_ADDR(BASE1), .ADDR_W(ADDR_W), .RD_WAIT(2)) dut1 (
        .CLK(clk), .RST(rst_n), .FRAME(frame), .IRDY(irdy), .CBE(cbe), .AD(ad),
        .TRDY(trdy1), .DEVSEL(devsel1), .STOP(stop1)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model [logic [31:0]];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_cbe[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] cbe_n);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (!cbe_n[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] state_of(input logic [31:0] addr);
        return (addr >= BASE1) ? 32'(dut1.state) : 32'(dut0.state);
    endfunction

    // ---------------- driver ----------------
    // One transaction. gap_at: data phase preceded by one IRDY=1 cycle (-1 none).
    // lat: edges from the address edge to the first transfer edge.
    task automatic burst(input string tag, input logic [31:0] addr, input logic [3:0] cmd,
                         input int n, input int gap_at, output int lat, output int n_done);
        int          i;
        int          budget;
        int          a_cyc;
        logic        stopped;
        logic        gap_done;
        logic [31:0] wa;
        logic [31:0] old;
        logic [31:0] exp_w;
        lat      = -1;
        n_done   = 0;
        stopped  = 1'b0;
        gap_done = 1'b0;
        @(negedge clk);
        frame = 1'b0; irdy = 1'b1; cbe = cmd; tb_ad = addr; tb_oe = 1'b1;
        @(negedge clk);
        a_cyc = cyc;
        chk({tag, " devsel@A+1"}, 32'(devsel), 32'd0);
        if (cmd == CMD_MEM_READ) begin
            tb_oe = 1'b0; cbe = 4'h0;
            chk({tag, " ad turnaround"}, 32'(ad_busy), 32'd0);
        end
        i = 0;
        while (i < n && !stopped) begin
            wa = addr + 32'(4 * i);
            if (cmd == CMD_MEM_WRITE) begin
                tb_ad = wr_data[i]; cbe = wr_cbe[i];
            end
            if (i == gap_at && !gap_done) begin
                gap_done = 1'b1;
                irdy = 1'b1; frame = 1'b0;
                @(negedge clk);
                continue;
            end
            irdy  = 1'b0;
            frame = (i == n - 1);
            if (cmd == CMD_MEM_READ) exp_q.push_back(model[wa]);
            budget = 0;
            while (trdy !== 1'b0 && budget < 16) begin
                @(negedge clk);
                budget++;
            end
            if (trdy !== 1'b0) begin
                chk({tag, " trdy timeout"}, 32'(trdy), 32'd0);
                exp_q = {};
                break;
            end
            if (lat < 0) lat = cyc + 1 - a_cyc;
            if (cmd == CMD_MEM_READ) begin
                exp_w = exp_q.pop_front();
                chk({tag, " rdata"}, ad, exp_w);
            end else begin
                old = model.exists(wa) ? model[wa] : 32'h0;
                model[wa] = merge(old, wr_data[i], wr_cbe[i]);
            end
            chk({tag, " stop"}, 32'(stop), (((wa >> 2) % DEPTH) == DEPTH - 1) ? 32'd0 : 32'd1);
            stopped = (stop === 1'b0);
            i++;
            n_done++;
            @(negedge clk);
        end
        if (stopped && frame == 1'b0) begin
            // Disconnected: keep offering data, nothing must be taken.
            if (cmd == CMD_MEM_WRITE) begin
                tb_ad = 32'hBAD0_BAD0; cbe = 4'h0;
            end
            repeat (2) begin
                chk({tag, " hold trdy"}, 32'(trdy), 32'd1);
                chk({tag, " hold stop"}, 32'(stop), 32'd0);
                chk({tag, " hold devsel"}, 32'(devsel), 32'd0);
                chk({tag, " hold ad"}, 32'(ad_busy), 32'd0);
                @(negedge clk);
            end
            frame = 1'b1;
            @(negedge clk);
        end
        frame = 1'b1; irdy = 1'b1; tb_oe = 1'b0; cbe = 4'h0;
        chk({tag, " done state"}, state_of(addr), 32'(ST_DONE));
        chk({tag, " done pins"}, {29'd0, trdy, devsel, stop}, 32'd7);
        chk({tag, " done ad"}, 32'(ad_busy), 32'd0);
        @(negedge clk);
        chk({tag, " idle state"}, state_of(addr), 32'(ST_IDLE));
    endtask

    // ---------------- directed sequence ----------------
    int lat;
    int nd;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset pins", {29'd0, trdy, devsel, stop}, 32'd7);
        chk("reset ad", 32'(ad_busy), 32'd0);
        chk("reset state", 32'(dut0.state), 32'(ST_IDLE));
        chk("reset idx", 32'(dut0.idx), 32'd0);
        rst_n = 1'b1;

        // Single write then single read at BASE+0x10
        wr_data = {32'hDEAD_BEEF}; wr_cbe = {4'h0};
        burst("wr single", BASE0 + 32'h10, CMD_MEM_WRITE, 1, -1, lat, nd);
        chk("wr single lat", 32'(lat), 32'd1);
        burst("rd single", BASE0 + 32'h10, CMD_MEM_READ, 1, -1, lat, nd);
        chk("rd single lat", 32'(lat), 32'd2);

        // Byte-enable burst over all-ones background
        wr_data = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        wr_cbe  = {4'h0, 4'h0, 4'h0, 4'h0};
        burst("wr fill", BASE0, CMD_MEM_WRITE, 4, -1, lat, nd);
        wr_data = {32'h1111_1111, 32'h2222_2222, 32'h3333_ABCD, 32'h4444_4444};
        wr_cbe  = {4'h0, 4'h0, 4'hC, 4'h0};
        burst("wr be", BASE0, CMD_MEM_WRITE, 4, -1, lat, nd);
        chk("wr be count", 32'(nd), 32'd4);
        burst("rd be", BASE0, CMD_MEM_READ, 4, -1, lat, nd);
        chk("rd be count", 32'(nd), 32'd4);

        // RD_WAIT=2 target, initiator wait mid-burst
        wr_data = {}; wr_cbe = {};
        for (int k = 0; k < 4; k++) begin
            wr_data.push_back($urandom);
            wr_cbe.push_back(4'h0);
        end
        burst("wr wait", BASE1 + 32'h20, CMD_MEM_WRITE, 4, -1, lat, nd);
        burst("rd wait", BASE1 + 32'h20, CMD_MEM_READ, 4, 2, lat, nd);
        chk("rd wait lat", 32'(lat), 32'd4);
        chk("rd wait count", 32'(nd), 32'd4);

        // Disconnect at the top word
        wr_data = {32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004};
        wr_cbe  = {4'h0, 4'h0, 4'h0, 4'h0};
        burst("wr top", BASE0 + 32'(4 * (DEPTH - 2)), CMD_MEM_WRITE, 4, -1, lat, nd);
        chk("wr top count", 32'(nd), 32'd2);
        burst("rd top", BASE0 + 32'(4 * (DEPTH - 2)), CMD_MEM_READ, 2, -1, lat, nd);
        burst("rd nowrap", BASE0, CMD_MEM_READ, 1, -1, lat, nd);

        // Miss: address one past the window, a hit address shown while busy
        @(negedge clk);
        frame = 1'b0; irdy = 1'b1; tb_oe = 1'b1; tb_ad = BASE0 + 32'(DEPTH * 4); cbe = CMD_MEM_WRITE;
        @(negedge clk);
        tb_ad = BASE0 + 32'h10; cbe = CMD_MEM_READ; irdy = 1'b0;
        @(negedge clk);
        chk("miss pins", {29'd0, trdy, devsel, stop}, 32'd7);
        chk("miss ad", 32'(ad_busy), 32'd0);
        chk("miss state", 32'(dut0.state), 32'(ST_BUSY));
        frame = 1'b1;
        @(negedge clk);
        chk("miss irdy low", 32'(dut0.state), 32'(ST_BUSY));
        irdy = 1'b1;
        @(negedge clk);
        chk("miss release", 32'(dut0.state), 32'(ST_IDLE));

        // Miss: unsupported command at an in-window address
        frame = 1'b0; tb_ad = BASE0 + 32'h10; cbe = 4'b0010;
        @(negedge clk);
        irdy = 1'b0;
        @(negedge clk);
        chk("badcmd pins", {29'd0, trdy, devsel, stop}, 32'd7);
        chk("badcmd state", 32'(dut0.state), 32'(ST_BUSY));
        frame = 1'b1; irdy = 1'b1; tb_oe = 1'b0;
        @(negedge clk);
        chk("badcmd release", 32'(dut0.state), 32'(ST_IDLE));

        // Reset in the middle of a read burst
        @(negedge clk);
        frame = 1'b0; irdy = 1'b1; tb_oe = 1'b1; tb_ad = BASE0 + 32'h10; cbe = CMD_MEM_READ;
        @(negedge clk);
        tb_oe = 1'b0; cbe = 4'h0; irdy = 1'b0;
        @(negedge clk);
        chk("rst pre trdy", 32'(trdy), 32'd0);
        chk("rst pre data", ad, 32'hDEAD_BEEF);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst mid pins", {29'd0, trdy, devsel, stop}, 32'd7);
        chk("rst mid ad", 32'(ad_busy), 32'd0);
        chk("rst mid state", 32'(dut0.state), 32'(ST_IDLE));
        frame = 1'b1; irdy = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        burst("rd after rst", BASE0 + 32'h10, CMD_MEM_READ, 1, -1, lat, nd);
        chk("rd after rst lat", 32'(lat), 32'd2);

        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pci_target_mem.md
Name: pci_target_mem

Overview:
- Parametrised PCI memory-space target: decodes a configurable base-address window and serves single and burst memory read/write transactions into an internal word array.
- Provides byte-enable writes, address auto-increment, configurable initial read latency, and target disconnect (STOP) at the top of the array.
- Sits on the shared FRAME/IRDY/TRDY/DEVSEL/AD/CBE bus alongside the initiator model.

Parameters:
- BASE_ADDR, 32'h0000_0000, window base; must be aligned to 4*2**ADDR_W.
- ADDR_W, 7, word-address bits; DEPTH = 2**ADDR_W words of 32 bits.
- RD_WAIT, 0, extra TRDY wait cycles before the first read data phase (0..7).

Ports:
- CLK  in  1  bus clock, all logic on rising edge.
- RST  in  1  asynchronous reset, active low.
- FRAME  in  1  transaction frame, active low.
- IRDY  in  1  initiator ready, active low.
- CBE  in  4  command in address phase; active-low byte enables in data phases.
- AD  inout  32  multiplexed address/data; driven only during read data phases, else high-Z.
- TRDY  out  1  target ready, active low.
- DEVSEL  out  1  device select, active low.
- STOP  out  1  target disconnect request, active low.

Behaviour:
- Reset (async, RST=0): TRDY=DEVSEL=STOP=1, AD released (Z), state IDLE, word index 0. Memory contents are not reset. Reset mid-transaction aborts it immediately.
- Address phase:
  - This is the first rising edge with FRAME=0 while in IDLE.
  - Hit requires AD[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2], AD[1:0]==2'b00, and CBE equal to 4'b0110 (read) or 4'b0111 (write).
  - On a hit, the index loads AD[ADDR_W+1:2].
  - On a miss or unsupported command, go to BUSY and ignore the bus until FRAME=1 and IRDY=1 are sampled, then return to IDLE.
- States: IDLE, BUSY, WR, RD_TA, RD, DONE.
- Write path:
  - Address edge → WR; DEVSEL=0 and TRDY=0 from the next cycle (one cycle after the address phase).
  - Each edge with IRDY=0 and TRDY=0 is a transfer: for each byte b with CBE[b]=0, write AD[8b+7:8b] into mem[index]; then index+1.
  - IRDY=1 is an initiator wait: no write, index held.
- Read path:
  - Address edge → RD_TA; DEVSEL=0 at A+1, AD still Z (turnaround).
  - AD is driven from A+2 with mem[index]. TRDY=0 from A+2+RD_WAIT. Enter RD.
  - On a transfer, index+1 and AD updates to the next word on the same edge. CBE is ignored for reads.
- Burst end:
  - A transfer sampled with FRAME=1 is the last data phase → DONE.
  - In DONE: TRDY=DEVSEL=STOP=1 and AD released for one cycle, then IDLE.
- Disconnect:
  - When the current index is DEPTH-1 in WR/RD and TRDY=0, drive STOP=0 together with TRDY=0 (disconnect with data).
  - After that transfer, if FRAME is still 0: TRDY=1, STOP=0, DEVSEL=0, AD released, no further transfers, until FRAME=1 is sampled → DONE.
  - The index never wraps within a transaction.
- Simultaneous events:
  - A transfer on the same edge that FRAME rises completes normally.
  - A new address phase is never accepted in DONE or BUSY. A back-to-back transaction is accepted only from IDLE.
- A transfer is never counted while TRDY=1.

Decomposition:
- Package pci_pkg: CMD_MEM_READ=4'b0110, CMD_MEM_WRITE=4'b0111, target state enum, shared across bus models.
- Sub-module pci_target_mem_array:
  - DEPTH x 32 array with per-byte write enables.
  - Synchronous write, combinational read.
  - No reset.
- The top level holds the FSM, decoder, index counter, and AD tristate.

Test Plan:
- Single write 32'hDEAD_BEEF to BASE+0x10 (CBE=0000), then single read of BASE+0x10 → DEVSEL=0 at A+1, AD=32'hDEAD_BEEF with TRDY=0 at A+2, DONE then IDLE.
- 4-word burst write at BASE+0 with data phase 2 using CBE=4'b1100 over prior 32'hFFFF_FFFF → read-back returns 32'hFFFF_xxxx, upper half preserved, lower half written.
- RD_WAIT=2 read with IRDY=1 for one cycle mid-burst → TRDY first low at A+4, index holds during the IRDY wait, data sequence is contiguous.
- Burst write starting at word DEPTH-2 with FRAME held low → two transfers, STOP=0 on the second, TRDY=1 afterwards until FRAME=1, no write past DEPTH-1.
- Address BASE+DEPTH*4, or CBE=4'b0010 → DEVSEL/TRDY stay 1, AD stays Z, block returns to IDLE only after FRAME=IRDY=1.
- Assert RST=0 mid-read burst → TRDY/DEVSEL/STOP=1 and AD=Z immediately; the next transaction after reset completes normally.
